// File: rtl/ks_adder_pipe.sv
// ks_adder_pipe: pipelined Kogge-Stone adder/subtractor (s = a + b + ci, or a - b - ci).
// Latency 2 + popcount(STAGE_MASK[LEVELS-1:0]) cycles from accept to out_valid; 1 beat/cycle.
// Backpressure: each register stage is ready when empty or when its successor is ready, so bubbles collapse.
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake; a, b, ci and sub are captured on accept
//   a, b                 WIDTH-bit operands
//   ci                   carry-in (add) or borrow-in (sub)
//   sub                  0: add, 1: subtract
//   out_valid/out_ready  result handshake; outputs hold while stalled
//   s                    sum or difference
//   co                   carry out of MSB (sub: 1 = no borrow)
//   ovf                  two's-complement signed overflow
//   zero                 s == 0
module ks_adder_pipe #(
  parameter int          WIDTH      = 64,
  parameter logic [31:0] STAGE_MASK = 32'd4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = $clog2(WIDTH);

  // Generate/propagate vectors carry one extra position at index 0 that holds the
  // carry-in as a generate bit; operand bit i lives at index i+1.
  typedef struct packed {
    logic [WIDTH:0]   g;
    logic [WIDTH:0]   p;
    logic [WIDTH-1:0] p0;
  } beat_t;

  // node[k] feeds prefix level k; node[LEVELS] feeds the output stage.
  beat_t node     [LEVELS+1];
  logic  node_vld [LEVELS+1];
  logic  node_rdy [LEVELS+1];

  // ---------------------------------------------------------------- stage 0
  logic       [WIDTH-1:0] b_c;
  logic                   c_c;
  beat_t                  cond;
  logic                   s0_vld;
  beat_t                  s0_dat;

  always_comb begin
    b_c     = sub ? ~b : b;
    c_c     = sub ? ~ci : ci;
    cond.p0 = a ^ b_c;
    cond.g  = {a & b_c, c_c};
    // Index 0 never propagates: the carry-in is a pure generate.
    cond.p  = {a ^ b_c, 1'b0};
  end

  assign in_ready = ~s0_vld | node_rdy[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_vld <= 1'b0;
      s0_dat <= '0;
    end else if (in_ready) begin
      s0_vld <= in_valid;
      if (in_valid) s0_dat <= cond;
    end
  end

  assign node[0]     = s0_dat;
  assign node_vld[0] = s0_vld;

  // ---------------------------------------------------------- prefix levels
  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int D = 1 << k;
    beat_t res;

    // Positions below the span already cover every lower bit and pass through;
    // the top level naturally spans only the bits that exist.
    always_comb begin
      res = node[k];
      for (int i = D; i <= WIDTH; i++) begin
        res.g[i] = node[k].g[i] | (node[k].p[i] & node[k].g[i-D]);
        res.p[i] = node[k].p[i] & node[k].p[i-D];
      end
    end

    if (STAGE_MASK[k]) begin : g_reg
      logic  r_vld;
      beat_t r_dat;

      assign node_rdy[k] = ~r_vld | node_rdy[k+1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_vld <= 1'b0;
          r_dat <= '0;
        end else if (node_rdy[k]) begin
          r_vld <= node_vld[k];
          if (node_vld[k]) r_dat <= res;
        end
      end

      assign node_vld[k+1] = r_vld;
      assign node[k+1]     = r_dat;
    end else begin : g_pass
      assign node_rdy[k]   = node_rdy[k+1];
      assign node_vld[k+1] = node_vld[k];
      assign node[k+1]     = res;
    end
  end

  // ----------------------------------------------------------- output stage
  beat_t            fin;
  logic [WIDTH-1:0] sum_n;
  logic             co_n;
  logic             ovf_n;
  logic             unused_p;

  assign fin   = node[LEVELS];
  // node g[i] is the carry into operand bit i.
  assign sum_n = fin.p0 ^ fin.g[WIDTH-1:0];
  // For power-of-two widths the MSB group stops one position short of the
  // carry-in; fold it in here. Otherwise p[WIDTH] is already 0 and this is a no-op.
  assign co_n  = fin.g[WIDTH] | (fin.p[WIDTH] & fin.g[0]);
  assign ovf_n = fin.g[WIDTH-1] ^ co_n;
  // Lower group-propagate bits are not needed once the prefix is complete.
  assign unused_p = ^fin.p[WIDTH-1:0];

  assign node_rdy[LEVELS] = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (node_rdy[LEVELS]) begin
      out_valid <= node_vld[LEVELS];
      if (node_vld[LEVELS]) begin
        s    <= sum_n;
        co   <= co_n;
        ovf  <= ovf_n;
        zero <= ~|sum_n;
      end
    end
  end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Bench for ks_adder_pipe: four configurations driven by one shared stimulus stream.
//   0: W=64 mask=4 (L=3)   1: W=8 mask=0 (L=2)   2: W=8 mask=all (L=5)   3: W=64 mask=all (L=8)
module tb_ks_adder_pipe;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } res_t;

  localparam int WD  [4] = '{64, 8, 8, 64};
  localparam int LAT [4] = '{3, 2, 5, 8};

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        ci;
  logic        sub;

  logic        ir0, ir1, ir2, ir3;
  logic        ov0, ov1, ov2, ov3;
  logic        co0, co1, co2, co3;
  logic        of0, of1, of2, of3;
  logic        z0, z1, z2, z3;
  logic [63:0] s0, s3;
  logic [7:0]  s1, s2;

  logic [3:0]  in_rdy;
  logic [3:0]  out_vld;
  res_t        outs [4];

  int n_cmp = 0;
  int n_bad = 0;

  res_t q [4][$];
  logic held     [4];
  res_t held_val [4];
  res_t got      [4];

  ks_adder_pipe #(.WIDTH(64), .STAGE_MASK(32'd4)) u_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(ov0), .out_ready(out_ready), .s(s0), .co(co0), .ovf(of0), .zero(z0));
  ks_adder_pipe #(.WIDTH(8), .STAGE_MASK(32'd0)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .a(a[7:0]), .b(b[7:0]), .ci(ci), .sub(sub),
    .out_valid(ov1), .out_ready(out_ready), .s(s1), .co(co1), .ovf(of1), .zero(z1));
  ks_adder_pipe #(.WIDTH(8), .STAGE_MASK(32'hFFFF_FFFF)) u_d2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .a(a[7:0]), .b(b[7:0]), .ci(ci), .sub(sub),
    .out_valid(ov2), .out_ready(out_ready), .s(s2), .co(co2), .ovf(of2), .zero(z2));
  ks_adder_pipe #(.WIDTH(64), .STAGE_MASK(32'hFFFF_FFFF)) u_d3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3), .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(ov3), .out_ready(out_ready), .s(s3), .co(co3), .ovf(of3), .zero(z3));

  assign in_rdy  = {ir3, ir2, ir1, ir0};
  assign out_vld = {ov3, ov2, ov1, ov0};
  assign outs[0] = {s0, co0, of0, z0};
  assign outs[1] = {56'd0, s1, co1, of1, z1};
  assign outs[2] = {56'd0, s2, co2, of2, z2};
  assign outs[3] = {s3, co3, of3, z3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic on w-bit operands.
  function automatic res_t model(input int w, input logic [63:0] ta, input logic [63:0] tb,
                                 input logic tci, input logic tsub);
    res_t r;
    logic signed [67:0] pw, half, ua, ub, uc, tot, sa, sb, st;
    pw   = 68'sd1 <<< w;
    half = pw >>> 1;
    ua   = $signed({4'b0, ta}) & (pw - 68'sd1);
    ub   = $signed({4'b0, tb}) & (pw - 68'sd1);
    uc   = $signed({67'b0, tci});
    tot  = tsub ? (ua - ub - uc) : (ua + ub + uc);
    r.s  = tot[63:0] & 64'(pw - 68'sd1);
    r.co = tsub ? (ua >= ub + uc) : (tot >= pw);
    sa   = ua[w-1] ? (ua - pw) : ua;
    sb   = ub[w-1] ? (ub - pw) : ub;
    st   = tsub ? (sa - sb - uc) : (sa + sb + uc);
    r.ovf  = (st >= half) || (st < -half);
    r.zero = (r.s == 64'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rand_op();
    case ($urandom % 8)
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0080;
      3: return 64'h7FFF_FFFF_FFFF_FF7F;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Monitor: scoreboard pops on every output transfer, pushes on every accept,
  // and checks that a stalled result stays put.
  initial begin
    for (int d = 0; d < 4; d++) held[d] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (rst) begin
          q[d].delete();
          held[d] = 1'b0;
        end else begin
          if (held[d]) chk($sformatf("stall_hold_d%0d", d), {out_vld[d], outs[d]}, {1'b1, held_val[d]});
          if (out_vld[d] && out_ready) begin
            if (q[d].size() == 0) begin
              chk($sformatf("unexpected_out_d%0d", d), {out_vld[d], outs[d]}, 68'd0);
            end else begin
              chk($sformatf("result_d%0d", d), {1'b0, outs[d]}, {1'b0, q[d].pop_front()});
            end
          end
          held[d]     = out_vld[d] & ~out_ready;
          held_val[d] = outs[d];
          if (in_valid && in_rdy[d]) q[d].push_back(model(WD[d], a, b, ci, sub));
        end
      end
    end
  end

  // Single beat into an empty pipe: measures per-configuration latency and
  // captures the first result each configuration emits.
  task automatic one_beat(input logic [63:0] ta, input logic [63:0] tb, input logic tci, input logic tsub);
    int seen [4];
    for (int d = 0; d < 4; d++) seen[d] = 0;
    @(posedge clk); #1;
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int d = 0; d < 4; d++) begin
        if (out_vld[d] && seen[d] == 0) begin
          seen[d] = c;
          got[d]  = outs[d];
        end
      end
    end
    for (int d = 0; d < 4; d++) chk($sformatf("latency_d%0d", d), seen[d], LAT[d]);
  endtask

  task automatic drain();
    int left;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    left = 1;
    for (int c = 0; c < 100 && left != 0; c++) begin
      @(posedge clk); #1;
      left = q[0].size() + q[1].size() + q[2].size() + q[3].size();
    end
    chk("drain_pending", left, 0);
  endtask

  task automatic rand_phase(input int cycles, input int rdy_pct, input int vld_pct);
    repeat (cycles) begin
      @(posedge clk); #1;
      in_valid  = ($urandom % 100) < vld_pct;
      out_ready = ($urandom % 100) < rdy_pct;
      a   = rand_op();
      b   = rand_op();
      ci  = $urandom % 2;
      sub = $urandom % 2;
    end
    drain();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) chk($sformatf("reset_state_d%0d", d), {out_vld[d], outs[d]}, 68'd0);
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_reset", in_rdy, 4'hF);

    // Pin the reference model against hand-computed results.
    chk("model_t1", model(64, '1, 64'd0, 1'b1, 1'b0), {1'b0, 64'h0, 1'b1, 1'b0, 1'b1});
    chk("model_t2", model(64, 64'd5, 64'd7, 1'b0, 1'b1), {1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});
    chk("model_t3a", model(8, 64'h7F, 64'h01, 1'b0, 1'b0), {1'b0, 64'h80, 1'b0, 1'b1, 1'b0});
    chk("model_t3b", model(8, 64'h80, 64'h01, 1'b0, 1'b1), {1'b0, 64'h7F, 1'b1, 1'b1, 1'b0});

    // Directed cases with literal expectations on the DUTs themselves.
    one_beat('1, 64'd0, 1'b1, 1'b0);
    chk("t1_d0", {1'b0, got[0]}, {1'b0, 64'h0, 1'b1, 1'b0, 1'b1});
    chk("t1_d3", {1'b0, got[3]}, {1'b0, 64'h0, 1'b1, 1'b0, 1'b1});
    one_beat(64'd5, 64'd7, 1'b0, 1'b1);
    chk("t2a_d0", {1'b0, got[0]}, {1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0});
    one_beat(64'd7, 64'd5, 1'b0, 1'b1);
    chk("t2b_d3", {1'b0, got[3]}, {1'b0, 64'h2, 1'b1, 1'b0, 1'b0});
    one_beat(64'h7F, 64'h01, 1'b0, 1'b0);
    chk("t3a_d1", {1'b0, got[1]}, {1'b0, 64'h80, 1'b0, 1'b1, 1'b0});
    chk("t3a_d2", {1'b0, got[2]}, {1'b0, 64'h80, 1'b0, 1'b1, 1'b0});
    one_beat(64'h80, 64'h01, 1'b0, 1'b1);
    chk("t3b_d1", {1'b0, got[1]}, {1'b0, 64'h7F, 1'b1, 1'b1, 1'b0});

    // Full occupancy: with the output stalled, each pipe takes exactly L beats.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = $urandom % 2; sub = $urandom % 2;
    end
    in_valid = 1'b0;
    for (int d = 0; d < 4; d++) chk($sformatf("occupancy_d%0d", d), q[d].size(), LAT[d]);
    drain();

    // Streaming at full rate, then with random backpressure and bubbles.
    rand_phase(10000, 100, 100);
    rand_phase(2000, 50, 70);

    // Reset with three beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1;
    repeat (3) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; ci = $urandom % 2; sub = $urandom % 2;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_midflight_out_valid", out_vld, 4'h0);
    @(negedge clk); #1 rst = 1'b0;
    one_beat(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
